// File: rtl/word_serializer_if.sv
// ----------------------------------------------------------------------------
// word_serializer_if
//
// Groups the handshake and data signals of word_serializer. clk and rst are not
// part of the interface.
//
// Modports:
//   slave  - the serializer. It drives in_ready, f0..f7, s, out_valid,
//            out_last and frame_count. It samples in_valid, in_w0..in_w7 and
//            out_ready.
//   master - the surrounding logic: the frame source, the downstream mux and
//            the beat consumer. It uses the opposite directions.
//
// Signals:
//   in_valid, in_ready        frame load handshake
//   in_w0..in_w7   [WIDTH]    frame words; word n is held on fn
//   f0..f7         [WIDTH]    held frame words, fed to the mux data inputs
//   s              [3]        mux select
//   out_valid, out_ready      beat handshake
//   out_last                  the current beat is the final beat of the frame
//   frame_count    [8]        completed frames, wraps from 255 to 0
// ----------------------------------------------------------------------------
interface word_serializer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_w0, in_w1, in_w2, in_w3, in_w4, in_w5, in_w6, in_w7;
  logic [WIDTH-1:0] f0, f1, f2, f3, f4, f5, f6, f7;
  logic [2:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [7:0]       frame_count;

  modport slave (
    input  in_valid, in_w0, in_w1, in_w2, in_w3, in_w4, in_w5, in_w6, in_w7,
    input  out_ready,
    output in_ready, f0, f1, f2, f3, f4, f5, f6, f7, s, out_valid, out_last,
    output frame_count
  );

  modport master (
    output in_valid, in_w0, in_w1, in_w2, in_w3, in_w4, in_w5, in_w6, in_w7,
    output out_ready,
    input  in_ready, f0, f1, f2, f3, f4, f5, f6, f7, s, out_valid, out_last,
    input  frame_count
  );
endinterface

// File: rtl/word_serializer.sv
// ----------------------------------------------------------------------------
// word_serializer
//
// Feeds a downstream 8:1 word multiplexer.
//
// - It captures an eight-word frame in a single load handshake.
// - It holds the frame on f0..f7.
// - It steps the select s through the frame. s advances one beat for each
//   accepted output handshake.
// - It counts completed frames in frame_count, which wraps.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  word_serializer_if.slave (see word_serializer_if.sv)
//
// Optional feature, macro WORD_SERIALIZER_SKIP_ZERO_EN:
//   When the macro is defined, words equal to zero are skipped:
//   - s visits only the nonzero indices, in ascending order.
//   - out_last marks the highest nonzero index.
//   - An all-zero frame is captured and counted but produces no beats.
//   When the macro is not defined, all eight beats 0..7 are always sent.
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module word_serializer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  word_serializer_if.slave     bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] in_w [8];
  logic [WIDTH-1:0] f_q  [8];
  logic [2:0]       s_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [7:0]       frame_count_q;

  // Bit n is set when word n takes part in the frame. in_mask covers the
  // incoming words and f_mask covers the held ones.
  logic [7:0]       in_mask;
  logic [7:0]       f_mask;

  assign in_w[0] = bus.in_w0;
  assign in_w[1] = bus.in_w1;
  assign in_w[2] = bus.in_w2;
  assign in_w[3] = bus.in_w3;
  assign in_w[4] = bus.in_w4;
  assign in_w[5] = bus.in_w5;
  assign in_w[6] = bus.in_w6;
  assign in_w[7] = bus.in_w7;

`ifdef WORD_SERIALIZER_SKIP_ZERO_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    in_mask = '0;
    f_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      in_mask[i] = (in_w[i] != '0);
      f_mask[i]  = (f_q[i]  != '0);
    end
  end
`else
  assign in_mask = 8'hff;
  assign f_mask  = 8'hff;
`endif

  // Lowest set index of m.
  function automatic logic [2:0] first_idx(input logic [7:0] m);
    first_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) first_idx = 3'(i);
  endfunction

  // Highest set index of m.
  function automatic logic [2:0] last_idx(input logic [7:0] m);
    last_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) last_idx = 3'(i);
  endfunction

  // Lowest set index of m above cur. Called only when cur is not the last
  // index, so such an index always exists.
  function automatic logic [2:0] next_idx(input logic [7:0] m, input logic [2:0] cur);
    next_idx = cur;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_idx = 3'(i);
  endfunction

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      // NOTE: the frame registers are cleared on reset because they are
      // visible outputs with defined reset values, not scratch storage.
      for (int i = 0; i < 8; i++) f_q[i] <= '0;
      s_q           <= 3'd0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            for (int i = 0; i < 8; i++) f_q[i] <= in_w[i];
            if (in_mask == 8'd0) begin
              // Nothing to send. The frame counts as complete at once.
              frame_count_q <= frame_count_q + 8'd1;
            end else begin
              state       <= SEND;
              s_q         <= first_idx(in_mask);
              out_last_q  <= (first_idx(in_mask) == last_idx(in_mask));
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end
          end
        end

        SEND: begin
          // out_valid is always high in SEND. out_ready alone accepts the beat.
          if (bus.out_ready) begin
            if (out_last_q) begin
              state         <= IDLE;
              s_q           <= 3'd0;
              out_valid_q   <= 1'b0;
              out_last_q    <= 1'b0;
              in_ready_q    <= 1'b1;
              frame_count_q <= frame_count_q + 8'd1;
            end else begin
              s_q        <= next_idx(f_mask, s_q);
              out_last_q <= (next_idx(f_mask, s_q) == last_idx(f_mask));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.f0          = f_q[0];
  assign bus.f1          = f_q[1];
  assign bus.f2          = f_q[2];
  assign bus.f3          = f_q[3];
  assign bus.f4          = f_q[4];
  assign bus.f5          = f_q[5];
  assign bus.f6          = f_q[6];
  assign bus.f7          = f_q[7];
  assign bus.s           = s_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: doc/word_serializer.md
# word_serializer

Upstream feeder for the 8:1 word multiplexer in the datapath. Accepts a frame of eight WIDTH-bit words in one load handshake and holds them on registered source outputs f0..f7. It then steps the 3-bit select s through the frame one beat per accepted output handshake, so the downstream Mux8x1 emits the words serially on y. Also keeps a wrapping count of completed frames for debug/performance reads.

## Interface
- WIDTH, 32, width of every data word (f0..f7, in_w0..in_w7); downstream mux is instantiated at 32.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- in_valid  in  1  frame present on in_w0..in_w7.
- in_ready  out  1  block can accept a frame; registered.
- in_w0..in_w7  in  WIDTH each  frame words; index n goes to fn.
- f0..f7  out  WIDTH each  held frame words; wire directly to mux data inputs.
- s  out  3  mux select; registered.
- out_valid  out  1  y of downstream mux (selected by s) is a valid beat.
- out_ready  in  1  consumer takes the current beat.
- out_last  out  1  current beat is the final beat of the frame.
- frame_count  out  8  completed frames, wraps 255 -> 0.

## Operation
- States: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. On in_valid && in_ready: capture in_w0..in_w7 into f0..f7, s <= first beat index (0 without macro), go SEND.
- SEND: in_ready=0, out_valid=1. Beat accepted when out_valid && out_ready.
  - Accepted, not last: s <= next beat index.
  - Accepted, last: go IDLE, frame_count <= frame_count+1, s <= 0.
  - Not accepted: s, f0..f7 and out_valid held stable (no retraction).
- out_last = out_valid && (s is the last beat index); 7 without macro.
- f0..f7 change only on frame capture or reset; stable for the whole SEND phase and in IDLE.
- in_valid in SEND ignored (in_ready=0); frame not captured.
- Reset values: f0..f7=0, s=0, out_valid=0, out_last=0, in_ready=1, frame_count=0, state IDLE.
- Reset mid-frame: remaining beats discarded, frame not counted, reset values next cycle.

## Timing
- Capture edge N (in_valid&&in_ready): cycle N+1 f0..f7 valid, s=first index, out_valid=1, in_ready=0.
- With out_ready held 1: 8 beats in cycles N+1..N+8 at s=0..7; cycle N+9 IDLE, in_ready=1.
- Minimum frame period 9 cycles (no capture in the cycle the last beat is taken).
- frame_count visible incremented the cycle after the last beat is accepted.
- Downstream mux is combinational: y valid in the same cycle as out_valid/s.

## Configuration
- WORD_SERIALIZER_SKIP_ZERO_EN defined: beats whose word equals 0 are skipped. First index = lowest n with fn != 0; next = next higher nonzero index; last = highest nonzero index (drives out_last). All-zero frame: captured, in_ready stays 1 path: state stays IDLE, out_valid never asserted, frame_count increments the cycle after capture.
- Not defined: all eight beats 0..7 always sent in order, zero words included.

## Test plan
- Reset: assert rst 2 cycles mid-SEND at s=3 -> next cycle s=0, out_valid=0, in_ready=1, f0..f7=0, frame_count unchanged from pre-frame value 0.
- Full frame, out_ready=1: load words 10..17 -> s=0..7 on consecutive cycles, y=10..17, out_last only with y=17, frame_count=1, in_ready=1 one cycle later.
- Backpressure: out_ready low 3 cycles at s=2 -> s=2, y=12, out_valid=1 held; release -> s=3 next cycle, y=13.
- Load blocked: in_valid=1 with different words during SEND -> f0..f7 keep 10..17; new frame captured only after return to IDLE.
- frame_count wrap: 256 frames -> frame_count reads 0.
- With WORD_SERIALIZER_SKIP_ZERO_EN: words {0,11,0,13,0,0,16,0} -> beats s=1,3,6, y=11,13,16, out_last with 16; all-zero frame -> no out_valid, frame_count+1.
